rr_gate_arbiter: RTL and testbench

//  Round-robin arbiter sharing one gated free-running WIDTH-bit counter

---
 rtl/rr_gate_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_gate_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_gate_arbiter.sv
// Round-robin arbiter for a shared, enable-gated counter datapath.
// One requester owns the datapath at a time. Each tenure is bounded by a
// hold timer, and every tenure is followed by a dead cycle before the next
// arbitration, so ownership always changes cleanly.
module rr_gate_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  done,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [NREQ-1:0]  gnt,
    output logic             gnt_valid,
    output logic [2:0]       gnt_id,
    output logic             en_out,
    output logic [WIDTH-1:0] cnt_out,
    output logic [7:0]       preempt_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state_reg;
    logic [NREQ-1:0] gnt_reg;
    logic [2:0]      gnt_id_reg;
    logic [2:0]      last_reg;
    logic [3:0]      hold_reg;
    logic [7:0]      preempt_reg;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic            owner_req;
    logic            owner_done;
    logic            expired;
    logic            release_now;

    // Rotating-priority search: first requester after the last owner wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_reg) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Owner's own request/done are picked out with the one-hot grant, so
    // non-owner activity cannot influence the release decision.
    always_comb begin
        owner_req   = |(req & gnt_reg);
        owner_done  = |(done & gnt_reg);
        expired     = (hold_reg == 4'(HOLD_MAX));
        release_now = owner_done || !owner_req || expired;
    end

    // Arbitration FSM with registered grant, owner id, pointer, timer and
    // forced-release counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            gnt_id_reg  <= '0;
            last_reg    <= 3'(NREQ - 1);
            hold_reg    <= '0;
            preempt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        gnt_reg    <= ONE_HOT0 << win_idx;
                        gnt_id_reg <= 3'(win_idx);
                        last_reg   <= 3'(win_idx);
                        hold_reg   <= 4'd1;
                        state_reg  <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt_reg    <= '0;
                        gnt_id_reg <= '0;
                        hold_reg   <= '0;
                        state_reg  <= GAP;
                        // Only a pure timer expiry counts as a preemption.
                        if (expired && owner_req && !owner_done &&
                            preempt_reg != 8'hFF) begin
                            preempt_reg <= preempt_reg + 8'd1;
                        end
                    end else begin
                        hold_reg <= hold_reg + 4'd1;
                    end
                end
                GAP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt         = gnt_reg;
    assign gnt_id      = gnt_id_reg;
    assign gnt_valid   = |gnt_reg;
    assign en_out      = gnt_valid;
    assign preempt_cnt = preempt_reg;

    // Count data is passed through only while someone owns the datapath.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cnt_mask
            assign cnt_out[gi] = cnt_in[gi] & gnt_valid;
        end
    endgenerate

endmodule

// File: tb/tb_rr_gate_arbiter.sv
// Bench for rr_gate_arbiter: directed stimulus pushes expected tenures
// (owner, length, preempt count after release) into a scoreboard; a
// negedge monitor reconstructs tenures from gnt and pops/compares them.
module tb_rr_gate_arbiter;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int HOLD_MAX = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  done;
    logic [WIDTH-1:0] cnt_in;
    logic [NREQ-1:0]  gnt;
    logic             gnt_valid;
    logic [2:0]       gnt_id;
    logic             en_out;
    logic [WIDTH-1:0] cnt_out;
    logic [7:0]       preempt_cnt;

    rr_gate_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .done        (done),
        .cnt_in      (cnt_in),
        .gnt         (gnt),
        .gnt_valid   (gnt_valid),
        .gnt_id      (gnt_id),
        .en_out      (en_out),
        .cnt_out     (cnt_out),
        .preempt_cnt (preempt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int len;
        int pre;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_tenure(input int id, input int len, input int pre);
        exp_t e;
        e.id  = id;
        e.len = len;
        e.pre = pre;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cnt_in = cnt_in + 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) tick();
        reset_n = 1'b1;
    endtask

    // Grant must never be more than one-hot.
    assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt));

    // Monitor: invariants every cycle, tenure reconstruction and scoreboard pop.
    int              ten_len  = 0;
    int              gap_len  = 0;
    int              ten_no   = 0;
    bit              have_prev = 1'b0;
    bit              rst_seen  = 1'b0;
    logic [NREQ-1:0] cur_gnt   = '0;
    int              cur_id    = 0;

    always @(negedge clk) begin
        exp_t e;
        check("gnt_valid", gnt_valid, |gnt);
        check("en_out", en_out, |gnt);
        check("cnt_out", cnt_out, (|gnt) ? cnt_in : '0);
        check("onehot0", $onehot0(gnt), 1);
        if (!reset_n) rst_seen = 1'b1;
        if (gnt != '0) begin
            check("gnt_id_match", gnt, 32'(1) << gnt_id);
            if (ten_len == 0) begin
                if (have_prev && !rst_seen) check("gap_ge2", gap_len >= 2, 1);
                cur_gnt  = gnt;
                cur_id   = int'(gnt_id);
                rst_seen = 1'b0;
            end else begin
                check("gnt_stable", gnt, cur_gnt);
            end
            ten_len++;
        end else begin
            check("gnt_id_idle", gnt_id, 0);
            if (ten_len > 0) begin
                ten_no++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tenure_unexpected: owner=%0d len=%0d, expected none", cur_id, ten_len);
                end else begin
                    e = sb.pop_front();
                    $display("tenure %0d: owner=%0d len=%0d preempt=%0d (exp owner=%0d len=%0d preempt=%0d)",
                             ten_no, cur_id, ten_len, preempt_cnt, e.id, e.len, e.pre);
                    check("tenure_id", cur_id, e.id);
                    check("tenure_len", ten_len, e.len);
                    check("tenure_preempt", preempt_cnt, e.pre);
                end
                have_prev = 1'b1;
                gap_len   = 0;
                ten_len   = 0;
            end
            gap_len++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req     = '0;
        done    = '0;
        cnt_in  = '0;

        // 1/2: all requesting, rotating timer-forced tenures with wrap 3->0.
        req = 4'b1111;
        expect_tenure(0, 4, 1);
        expect_tenure(1, 4, 2);
        expect_tenure(2, 4, 3);
        expect_tenure(3, 4, 4);
        expect_tenure(0, 4, 5);
        do_reset(3);
        #2;
        check("rst_gnt", gnt, 0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_gnt_valid", gnt_valid, 0);
        check("rst_en_out", en_out, 0);
        check("rst_cnt_out", cnt_out, 0);
        check("rst_preempt", preempt_cnt, 0);
        tick();
        #2;
        check("t1_gnt", gnt, 4'b0001);
        check("t1_gnt_id", gnt_id, 0);
        check("t1_en_out", en_out, 1);
        check("t1_cnt_out", cnt_out, cnt_in);
        repeat (28) tick();
        #2;
        check("t2_gnt_after", gnt, 0);
        check("t2_preempt", preempt_cnt, 5);
        req = 4'b0000;
        tick();
        tick();

        // 3: single requester, done on 2nd grant cycle, re-win after gap.
        do_reset(2);
        req = 4'b0100;
        expect_tenure(2, 2, 0);
        expect_tenure(2, 1, 0);
        tick();
        #2;
        check("t3_gnt", gnt, 4'b0100);
        tick();
        done = 4'b0100;
        tick();
        done = 4'b0000;
        #2;
        check("t3_released", gnt, 0);
        tick();
        tick();
        #2;
        check("t3_regrant", gnt, 4'b0100);
        req = 4'b0000;
        tick();
        tick();
        tick();
        #2;
        check("t3_preempt", preempt_cnt, 0);

        // 4: owner 1 drops req and pulses done at expiry; done[3] ignored.
        do_reset(2);
        req = 4'b1010;
        expect_tenure(1, 4, 0);
        expect_tenure(3, 4, 1);
        tick();
        #2;
        check("t4_gnt", gnt, 4'b0010);
        check("t4_gnt_id", gnt_id, 1);
        tick();
        done = 4'b1000;
        tick();
        done = 4'b0000;
        tick();
        req  = 4'b1000;
        done = 4'b0010;
        tick();
        done = 4'b0000;
        #2;
        check("t4_released", gnt, 0);
        check("t4_preempt", preempt_cnt, 0);
        tick();
        tick();
        #2;
        check("t4_gnt3", gnt, 4'b1000);
        check("t4_gnt_id3", gnt_id, 3);
        repeat (4) tick();
        #2;
        check("t4_preempt3", preempt_cnt, 1);
        req = 4'b0000;
        tick();
        tick();

        // 5: reset during grant at hold=2, then req[0] wins first again.
        req = 4'b0100;
        expect_tenure(2, 2, 0);
        tick();
        #2;
        check("t5_gnt", gnt, 4'b0100);
        tick();
        reset_n = 1'b0;
        req     = 4'b1111;
        tick();
        #2;
        check("t5_rst_gnt", gnt, 0);
        check("t5_rst_cnt_out", cnt_out, 0);
        check("t5_rst_preempt", preempt_cnt, 0);
        reset_n = 1'b1;
        expect_tenure(0, 2, 0);
        tick();
        #2;
        check("t5_first_gnt", gnt, 4'b0001);
        check("t5_first_id", gnt_id, 0);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        #2;
        check("t5_released", gnt, 0);
        tick();

        // 6: no requests for 20 cycles while cnt_in counts 0..19.
        for (int i = 0; i < 20; i++) begin
            cnt_in = WIDTH'(i);
            #1;
            check("t6_gnt", gnt, 0);
            check("t6_en_out", en_out, 0);
            check("t6_cnt_out", cnt_out, 0);
            tick();
        end
        #2;
        check("t6_preempt", preempt_cnt, 0);
        tick();
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
